lshift_pipe: RTL and testbench



---
 rtl/lshift_pipe.sv | 94 +++++++++
 tb/tb_lshift_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lshift_pipe.sv
// lshift_pipe: pipelined left barrel shifter (logical shift or rotate).
// One register stage per shift-amount bit; stage k shifts by 2^k when its
// carried amount bit k is set. The whole pipeline advances together with a
// single enable, so it stalls only when a valid result is blocked downstream.
module lshift_pipe #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_rot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  logic [SHW-1:0]            valid_q, valid_d;
  logic [SHW-1:0][WIDTH-1:0] data_q,  data_d;
  logic [SHW-1:0][SHW-1:0]   shamt_q, shamt_d;
  logic [SHW-1:0]            rot_q,   rot_d;
  logic [SHW-1:0]            ovf_q,   ovf_d;

  // Stage inputs: stage 0 is fed from the input port, stage k from stage k-1.
  logic [SHW-1:0]              src_valid;
  logic [SHW-1:0][WIDTH-1:0]   src_data;
  logic [SHW-1:0][SHW-1:0]     src_shamt;
  logic [SHW-1:0]              src_rot;
  logic [SHW-1:0]              src_ovf;
  // Double-width shift result: upper half holds the bits pushed past the MSB.
  logic [SHW-1:0][2*WIDTH-1:0] ext;

  logic adv;

  assign adv       = ~valid_q[SHW-1] | out_ready;
  assign in_ready  = adv;

  assign src_valid = {valid_q[SHW-2:0], in_valid};
  assign src_data  = {data_q[SHW-2:0],  in_data};
  assign src_shamt = {shamt_q[SHW-2:0], in_shamt};
  assign src_rot   = {rot_q[SHW-2:0],   in_rot};
  assign src_ovf   = {ovf_q[SHW-2:0],   1'b0};

  // Per-stage shift/rotate and overflow accumulation; hold everything on stall.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    rot_d   = rot_q;
    ovf_d   = ovf_q;
    ext     = '0;
    for (int k = 0; k < SHW; k++) begin
      ext[k] = {{WIDTH{1'b0}}, src_data[k]} << (src_shamt[k][k] ? (2 ** k) : 0);
      if (adv) begin
        valid_d[k] = src_valid[k];
        data_d[k]  = ext[k][WIDTH-1:0] |
                     (src_rot[k] ? ext[k][2*WIDTH-1:WIDTH] : {WIDTH{1'b0}});
        shamt_d[k] = src_shamt[k];
        rot_d[k]   = src_rot[k];
        ovf_d[k]   = src_ovf[k] | (~src_rot[k] & (|ext[k][2*WIDTH-1:WIDTH]));
      end
    end
  end

  // Stage registers; reset discards every in-flight word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      shamt_q <= '0;
      rot_q   <= '0;
      ovf_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      rot_q   <= rot_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = valid_q[SHW-1];
  assign out_data  = data_q[SHW-1];
  assign out_ovf   = ovf_q[SHW-1];

  // The last stage's mode/amount and already-consumed amount bits are not needed.
  logic unused_bits;
  assign unused_bits = ^{shamt_q, rot_q};

endmodule

// File: tb/tb_lshift_pipe.sv
// Testbench for lshift_pipe (WIDTH = 8): directed and randomized handshake
// stimulus checked against an arithmetic reference model and a result queue.
module tb_lshift_pipe;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_rot, out_valid, out_ready, out_ovf;
  logic [W-1:0] in_data, out_data;
  logic [2:0]   in_shamt;

  always #5 clk = ~clk;

  lshift_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_rot(in_rot),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  typedef struct {
    logic [7:0] d;
    logic       ovf;
    int         cyc;
    int         stl;
  } exp_t;

  exp_t       q[$];
  int         total = 0, bad = 0, cyc = 0, stall_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: full product d * 2^s; low byte is the shift, high byte the spill.
  function automatic void model(input logic [7:0] d, input int s, input logic r,
                                output logic [7:0] od, output logic ovf);
    int full;
    full = int'(d) * (1 << s);
    if (r) begin
      od  = 8'((full % 256) | (full / 256));
      ovf = 1'b0;
    end else begin
      od  = 8'(full % 256);
      ovf = (full / 256) != 0;
    end
  endfunction

  task automatic drive_cycle(input logic v, input logic [7:0] d, input logic [2:0] s,
                             input logic r, input logic ordy, output logic acc);
    logic       cons;
    exp_t       e;
    logic [7:0] od;
    logic       ov;
    in_valid  = v;
    in_data   = d;
    in_shamt  = s;
    in_rot    = r;
    out_ready = ordy;
    @(negedge clk);
    chk("in_ready", in_ready, !out_valid || ordy);
    acc  = v && in_ready;
    cons = out_valid && ordy;
    if (prev_stall) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, prev_data);
      chk("stall_ovf", out_ovf, prev_ovf);
    end
    if (cons) begin
      chk("q_nonempty", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_ovf", out_ovf, e.ovf);
        chk("latency", cyc - e.cyc, 3 + stall_cnt - e.stl);
      end
    end
    if (acc) begin
      model(d, int'(s), r, od, ov);
      q.push_back('{d: od, ovf: ov, cyc: cyc, stl: stall_cnt});
    end
    prev_stall = out_valid && !ordy;
    prev_data  = out_data;
    prev_ovf   = out_ovf;
    if (prev_stall) stall_cnt++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] s, input logic r);
    logic acc;
    int   guard;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 20) begin
      drive_cycle(1'b1, d, s, r, 1'b1, acc);
      guard++;
    end
    chk("send_accept", acc, 1);
  endtask

  task automatic drain();
    logic acc;
    int   guard;
    guard = 0;
    while ((q.size() != 0 || out_valid) && guard < 50) begin
      drive_cycle(1'b0, 8'h00, 3'd0, 1'b0, 1'b1, acc);
      guard++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  initial begin
    logic acc;
    int   widx, guard;
    logic v, ordy;
    in_valid = 0; in_data = 0; in_shamt = 0; in_rot = 0; out_ready = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, acc);
      chk("idle_valid", out_valid, 0);
      chk("idle_data", out_data, 0);
      chk("idle_ovf", out_ovf, 0);
      chk("idle_ready", in_ready, 1);
    end

    // Logical shifts, back to back
    send(8'h5A, 3'd1, 1'b0);
    send(8'h5A, 3'd3, 1'b0);
    send(8'h01, 3'd7, 1'b0);
    drain();

    // Rotates
    send(8'h81, 3'd1, 1'b1);
    send(8'h5A, 3'd4, 1'b1);
    send(8'hF0, 3'd0, 1'b1);
    drain();

    // Backpressure: 6 words, out_ready low for cycles 5..9
    widx = 0;
    for (int i = 0; i < 16; i++) begin
      v    = widx < 6;
      ordy = !(i >= 5 && i <= 9);
      drive_cycle(v, 8'($urandom), 3'($urandom), 1'($urandom), ordy, acc);
      if (acc) widx++;
    end
    chk("bp_accepted", widx, 6);
    drain();

    // Reset mid-stream with 3 words in flight
    send(8'h11, 3'd1, 1'b0);
    send(8'h22, 3'd2, 1'b0);
    send(8'h33, 3'd3, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #2;
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_ovf", out_ovf, 0);
    chk("async_rst_ready", in_ready, 1);
    q.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
    send(8'hC3, 3'd2, 1'b0);
    drain();

    // Exhaustive with random handshakes
    for (int m = 0; m < 2; m++) begin
      for (int s = 0; s < 8; s++) begin
        for (int d = 0; d < 256; d++) begin
          acc   = 1'b0;
          guard = 0;
          while (!acc && guard < 200) begin
            v    = $urandom_range(0, 3) != 0;
            ordy = $urandom_range(0, 3) != 0;
            drive_cycle(v, v ? 8'(d) : 8'($urandom), 3'(s), 1'(m), ordy, acc);
            guard++;
          end
          if (!acc) chk("accept_timeout", acc, 1);
        end
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
